// File: rtl/ysyx_22050019_div_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_div_pkg
// Shared definitions for the multi-cycle divider:
//   - default operand width and iteration-counter width
//   - bit positions inside the one-hot div_type vector (ALU alu_sel[28:21] order)
//   - FSM state encodings
//   - onehot8(): one-hot test for the op-select vector
// ----------------------------------------------------------------------------
package ysyx_22050019_div_pkg;

   localparam int DIV_XLEN  = 64;
   localparam int DIV_CNT_W = 7;

   localparam int DIV_TYPE_REM   = 0;
   localparam int DIV_TYPE_REMU  = 1;
   localparam int DIV_TYPE_REMUW = 2;
   localparam int DIV_TYPE_REMW  = 3;
   localparam int DIV_TYPE_DIV   = 4;
   localparam int DIV_TYPE_DIVU  = 5;
   localparam int DIV_TYPE_DIVUW = 6;
   localparam int DIV_TYPE_DIVW  = 7;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // True when exactly one bit of the op-select vector is set.
   function automatic logic onehot8(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/ysyx_22050019_div_checker.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_div_checker
// Simulation checks for the divider: div_type must be one-hot whenever a
// request is presented to an idle divider outside reset.
// Ports:
//   clk      clock
//   i_rst    synchronous active-high reset
//   i_valid  div_valid
//   i_idle   divider FSM is in IDLE
//   i_type   div_type one-hot op select
// ----------------------------------------------------------------------------
import ysyx_22050019_div_pkg::*;

module ysyx_22050019_div_checker (
   input logic       clk,
   input logic       i_rst,
   input logic       i_valid,
   input logic       i_idle,
   input logic [7:0] i_type
);

   // Non-one-hot op selects are decoded as signed 64-bit div; flag them.
   always @(posedge clk) begin
      if (!i_rst && i_valid && i_idle) begin
         assert (onehot8(i_type));
      end
   end

endmodule

// File: rtl/ysyx_22050019_div_sign_fix.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_div_sign_fix
// Two-lane combinational sign handling used on both sides of the divider core.
// Per lane:
//   1. W ops take the low half, sign-extended (i_is_signed) or zero-extended.
//   2. The lane is negated when its own sign (signed ops only) XOR i_flip_* is 1.
//   3. With i_sext_out and a W op, the result is sign-extended from bit 31.
// Input side : i_is_signed=op signedness, flips=0, sext_out=0 -> magnitudes.
// Output side: i_is_signed=0, flips=required negations, sext_out=1.
// Ports:
//   i_a, i_b          lane values
//   i_is_signed       treat lanes as two's complement
//   i_is_w            32-bit (word) operation
//   i_sext_out        sign-extend word results from bit 31
//   i_flip_a/b        force a negation of the lane
//   o_a, o_b          processed lane values
//   o_neg_a/b         detected sign of the (extended) input lane
// ----------------------------------------------------------------------------
import ysyx_22050019_div_pkg::*;

module ysyx_22050019_div_sign_fix #(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic            i_is_signed,
   input  logic            i_is_w,
   input  logic            i_sext_out,
   input  logic            i_flip_a,
   input  logic            i_flip_b,
   output logic [XLEN-1:0] o_a,
   output logic [XLEN-1:0] o_b,
   output logic            o_neg_a,
   output logic            o_neg_b
);

   localparam int              HALF = XLEN / 2;
   localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};

   // Returns {sign_of_extended_input, processed_value}.
   function automatic logic [XLEN:0] fix_lane(
      input logic [XLEN-1:0] v,
      input logic            is_signed,
      input logic            is_w,
      input logic            sext_out,
      input logic            flip
   );
      logic [XLEN-1:0] ext;
      logic [XLEN-1:0] tmp;
      logic            neg;
      if (is_w) begin
         if (is_signed) begin
            ext = {{HALF{v[HALF-1]}}, v[HALF-1:0]};
         end else begin
            ext = {{HALF{1'b0}}, v[HALF-1:0]};
         end
      end else begin
         ext = v;
      end
      neg = is_signed & ext[XLEN-1];
      if (neg ^ flip) begin
         tmp = (~ext) + ONE;
      end else begin
         tmp = ext;
      end
      if (sext_out && is_w) begin
         tmp = {{HALF{tmp[HALF-1]}}, tmp[HALF-1:0]};
      end else begin
         tmp = tmp;
      end
      return {neg, tmp};
   endfunction

   // Both lanes share the same transformation.
   always_comb begin
      {o_neg_a, o_a} = fix_lane(i_a, i_is_signed, i_is_w, i_sext_out, i_flip_a);
      {o_neg_b, o_b} = fix_lane(i_b, i_is_signed, i_is_w, i_sext_out, i_flip_b);
   end

endmodule

// File: rtl/ysyx_22050019_divider_cycle.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_divider_cycle
// Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
// W variants, answering the ALU valid/stall/ok/ready offload handshake.
// Latency from accept to result_ok: 65 cycles (64-bit), 33 cycles (W),
// 1 cycle for divide-by-zero and signed overflow.
// Optional build macro: DIV_FLUSH_EN adds the flush input (abort to IDLE).
// Ports:
//   clk           clock
//   rst_n         synchronous reset, ACTIVE-HIGH despite the name
//   flush         (DIV_FLUSH_EN only) abort current op, return to IDLE
//   div_valid     request, held by the ALU while the op sits in EX
//   div_type      one-hot op select (alu_sel[28:21] order)
//   dividend_i    operand 1
//   divisor_i     operand 2
//   result_ready  downstream can take the result
//   div_out       quotient/remainder, registered; W results sign-extended
//   div_stall     pipeline hold (combinational)
//   result_ok     div_out valid (registered, high exactly in DONE)
// ----------------------------------------------------------------------------
import ysyx_22050019_div_pkg::*;

module ysyx_22050019_divider_cycle #(
   parameter int XLEN  = DIV_XLEN,
   parameter int CNT_W = DIV_CNT_W
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef DIV_FLUSH_EN
   input  logic            flush,
`endif
   input  logic            div_valid,
   input  logic [7:0]      div_type,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic            result_ready,
   output logic [XLEN-1:0] div_out,
   output logic            div_stall,
   output logic            result_ok
);

   localparam int               HALF     = XLEN / 2;
   localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   logic [1:0]      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quot;
   logic [XLEN-1:0] r_divisor;
   logic            r_neg_a;
   logic            r_neg_b;
   logic            r_is_rem;
   logic            r_is_w;
   logic [XLEN-1:0] r_div_out;
   logic            r_result_ok;

   logic            w_flush;
   logic            w_is_signed;
   logic            w_is_rem;
   logic            w_is_w;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_neg_a;
   logic            w_neg_b;
   logic [XLEN-1:0] w_dvd_op;
   logic [XLEN-1:0] w_min_mag;
   logic            w_div_zero;
   logic            w_ovf;
   logic [XLEN-1:0] w_special_res;
   logic [XLEN:0]   w_rem_sh;
   logic [XLEN:0]   w_diff;
   logic            w_no_borrow;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quot_nxt;
   logic [XLEN-1:0] w_q_fix;
   logic [XLEN-1:0] w_r_fix;
   logic            w_unused_qneg;
   logic            w_unused_rneg;

`ifdef DIV_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // Op decode; anything that is not one-hot falls back to signed 64-bit div.
   always_comb begin
      if (onehot8(div_type)) begin
         w_is_signed = div_type[DIV_TYPE_REM]  | div_type[DIV_TYPE_REMW] |
                       div_type[DIV_TYPE_DIV]  | div_type[DIV_TYPE_DIVW];
         w_is_rem    = div_type[DIV_TYPE_REM]  | div_type[DIV_TYPE_REMU] |
                       div_type[DIV_TYPE_REMUW] | div_type[DIV_TYPE_REMW];
         w_is_w      = div_type[DIV_TYPE_REMUW] | div_type[DIV_TYPE_REMW] |
                       div_type[DIV_TYPE_DIVUW] | div_type[DIV_TYPE_DIVW];
      end else begin
         w_is_signed = 1'b1;
         w_is_rem    = 1'b0;
         w_is_w      = 1'b0;
      end
   end

   // Operand magnitudes and signs at the op width.
   ysyx_22050019_div_sign_fix #(.XLEN(XLEN)) u_pre_fix (
      .i_a         (dividend_i),
      .i_b         (divisor_i),
      .i_is_signed (w_is_signed),
      .i_is_w      (w_is_w),
      .i_sext_out  (1'b0),
      .i_flip_a    (1'b0),
      .i_flip_b    (1'b0),
      .o_a         (w_abs_a),
      .o_b         (w_abs_b),
      .o_neg_a     (w_neg_a),
      .o_neg_b     (w_neg_b)
   );

   // Divide-by-zero and signed-overflow results, resolved in the accept cycle.
   always_comb begin
      if (w_is_w) begin
         w_dvd_op  = {{HALF{dividend_i[HALF-1]}}, dividend_i[HALF-1:0]};
         w_min_mag = ONE << (HALF - 1);
      end else begin
         w_dvd_op  = dividend_i;
         w_min_mag = ONE << (XLEN - 1);
      end
      w_div_zero = (w_abs_b == ZERO);
      w_ovf      = w_is_signed & w_neg_a & (w_abs_a == w_min_mag) &
                   w_neg_b & (w_abs_b == ONE);
      if (w_div_zero) begin
         w_special_res = w_is_rem ? w_dvd_op : ONES;
      end else if (w_ovf) begin
         w_special_res = w_is_rem ? ZERO : w_dvd_op;
      end else begin
         w_special_res = ZERO;
      end
   end

   // One restoring step: shift {rem,quot}, trial-subtract, keep on no borrow.
   always_comb begin
      w_rem_sh    = {r_rem, r_quot[XLEN-1]};
      w_diff      = w_rem_sh - {1'b0, r_divisor};
      w_no_borrow = ~w_diff[XLEN];
      if (w_no_borrow) begin
         w_rem_nxt = w_diff[XLEN-1:0];
      end else begin
         w_rem_nxt = w_rem_sh[XLEN-1:0];
      end
      w_quot_nxt = {r_quot[XLEN-2:0], w_no_borrow};
   end

   // Quotient negated when signs differ, remainder follows the dividend sign.
   ysyx_22050019_div_sign_fix #(.XLEN(XLEN)) u_post_fix (
      .i_a         (w_quot_nxt),
      .i_b         (w_rem_nxt),
      .i_is_signed (1'b0),
      .i_is_w      (r_is_w),
      .i_sext_out  (1'b1),
      .i_flip_a    (r_neg_a ^ r_neg_b),
      .i_flip_b    (r_neg_a),
      .o_a         (w_q_fix),
      .o_b         (w_r_fix),
      .o_neg_a     (w_unused_qneg),
      .o_neg_b     (w_unused_rneg)
   );

   // Divider FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_rem       <= ZERO;
         r_quot      <= ZERO;
         r_divisor   <= ZERO;
         r_neg_a     <= 1'b0;
         r_neg_b     <= 1'b0;
         r_is_rem    <= 1'b0;
         r_is_w      <= 1'b0;
         r_div_out   <= ZERO;
         r_result_ok <= 1'b0;
      end else if (w_flush) begin
         // Abort: the last delivered div_out is deliberately kept.
         r_state     <= IDLE;
         r_cnt       <= {CNT_W{1'b0}};
         r_result_ok <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (div_valid) begin
                  r_neg_a  <= w_neg_a;
                  r_neg_b  <= w_neg_b;
                  r_is_rem <= w_is_rem;
                  r_is_w   <= w_is_w;
                  if (w_div_zero || w_ovf) begin
                     r_div_out   <= w_special_res;
                     r_result_ok <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_rem     <= ZERO;
                     r_divisor <= w_abs_b;
                     // W dividends are parked in the upper half so that the
                     // first shift already brings in bit 31.
                     if (w_is_w) begin
                        r_quot <= {w_abs_a[HALF-1:0], {HALF{1'b0}}};
                        r_cnt  <= CNT_HALF;
                     end else begin
                        r_quot <= w_abs_a;
                        r_cnt  <= CNT_FULL;
                     end
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_rem  <= w_rem_nxt;
               r_quot <= w_quot_nxt;
               r_cnt  <= r_cnt - CNT_LAST;
               if (r_cnt == CNT_LAST) begin
                  r_div_out   <= r_is_rem ? w_r_fix : w_q_fix;
                  r_result_ok <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (result_ready) begin
                  r_result_ok <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_result_ok <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign div_stall = div_valid & (r_state != DONE) & ~w_flush;
   assign div_out   = r_div_out;
   assign result_ok = r_result_ok;

   ysyx_22050019_div_checker u_checker (
      .clk     (clk),
      .i_rst   (rst_n),
      .i_valid (div_valid),
      .i_idle  (r_state == IDLE),
      .i_type  (div_type)
   );

endmodule

// File: tb/tb_ysyx_22050019_divider_cycle.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050019_divider_cycle
// Directed self-checking bench for ysyx_22050019_divider_cycle. Inputs are
// driven 1 time unit after the rising edge, outputs sampled there as well.
// Build with +define+DIV_FLUSH_EN to include the flush scenario.
// ----------------------------------------------------------------------------
module tb_ysyx_22050019_divider_cycle;

   localparam logic [7:0] T_REM   = 8'h01;
   localparam logic [7:0] T_REMU  = 8'h02;
   localparam logic [7:0] T_REMUW = 8'h04;
   localparam logic [7:0] T_REMW  = 8'h08;
   localparam logic [7:0] T_DIV   = 8'h10;
   localparam logic [7:0] T_DIVU  = 8'h20;
   localparam logic [7:0] T_DIVUW = 8'h40;
   localparam logic [7:0] T_DIVW  = 8'h80;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        div_valid;
   logic [7:0]  div_type;
   logic [63:0] dividend_i;
   logic [63:0] divisor_i;
   logic        result_ready;
   logic [63:0] div_out;
   logic        div_stall;
   logic        result_ok;

   int checks;
   int errors;

   ysyx_22050019_divider_cycle dut (
      .clk          (clk),
      .rst_n        (rst_n),
`ifdef DIV_FLUSH_EN
      .flush        (flush),
`endif
      .div_valid    (div_valid),
      .div_type     (div_type),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .result_ready (result_ready),
      .div_out      (div_out),
      .div_stall    (div_stall),
      .result_ok    (result_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents a request and waits (bounded) for result_ok; lat=-1 on timeout.
   task automatic run_op(input logic [7:0] typ, input logic [63:0] a,
                         input logic [63:0] b, output int lat,
                         output logic [63:0] res, output logic stall0);
      div_type   = typ;
      dividend_i = a;
      divisor_i  = b;
      div_valid  = 1'b1;
      #1 stall0 = div_stall;
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (result_ok) begin
            lat = n;
            break;
         end
      end
      res = div_out;
   endtask

   // Accepts the result and retires the request.
   task automatic release_op();
      result_ready = 1'b1;
      @(posedge clk); #1;
      div_valid = 1'b0;
      div_type  = 8'h00;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (result_ok !== 1'b0 || div_out !== 64'd0 || div_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got ok=%b out=%h stall=%b expected 0 0 0",
                  result_ok, div_out, div_stall);
      end
      div_valid = 1'b1;
      div_type  = T_DIV;
      #1;
      checks++;
      if (div_stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_stall: got %b expected 1", div_stall);
      end
      @(posedge clk); #1;
      checks++;
      if (result_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept: got ok=%b expected 0", result_ok);
      end
      div_valid = 1'b0;
      div_type  = 8'h00;
      rst_n     = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_signed64();
      logic [7:0]  t [4];
      logic [63:0] a [4];
      logic [63:0] b [4];
      logic [63:0] e [4];
      int          lat;
      logic [63:0] res;
      logic        st;
      t[0] = T_DIV;  a[0] = 64'hFFFF_FFFF_FFFF_FFEC; b[0] = 64'd3;  e[0] = 64'hFFFF_FFFF_FFFF_FFFA;
      t[1] = T_REM;  a[1] = 64'hFFFF_FFFF_FFFF_FFEC; b[1] = 64'd3;  e[1] = 64'hFFFF_FFFF_FFFF_FFFE;
      t[2] = T_DIVU; a[2] = 64'hFFFF_FFFF_FFFF_FFFF; b[2] = 64'd16; e[2] = 64'h0FFF_FFFF_FFFF_FFFF;
      t[3] = T_REMU; a[3] = 64'd100;                 b[3] = 64'd7;  e[3] = 64'd2;
      for (int i = 0; i < 4; i++) begin
         run_op(t[i], a[i], b[i], lat, res, st);
         checks++;
         if (st !== 1'b1) begin
            errors++;
            $display("FAIL op64[%0d] stall: got %b expected 1", i, st);
         end
         checks++;
         if (lat !== 65) begin
            errors++;
            $display("FAIL op64[%0d] latency: got %0d expected 65", i, lat);
         end
         checks++;
         if (res !== e[i]) begin
            errors++;
            $display("FAIL op64[%0d] value: got %h expected %h", i, res, e[i]);
         end
         release_op();
      end
   endtask

   task automatic test_word();
      logic [7:0]  t [5];
      logic [63:0] a [5];
      logic [63:0] b [5];
      logic [63:0] e [5];
      int          lat;
      logic [63:0] res;
      logic        st;
      t[0] = T_DIVUW; a[0] = 64'h0000_0001_8000_0000; b[0] = 64'd2;  e[0] = 64'h0000_0000_4000_0000;
      t[1] = T_REMW;  a[1] = 64'h0000_0000_FFFF_FFF9; b[1] = 64'd2;  e[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      t[2] = T_DIVW;  a[2] = 64'h0000_0000_FFFF_FFF9; b[2] = 64'd2;  e[2] = 64'hFFFF_FFFF_FFFF_FFFD;
      t[3] = T_REMUW; a[3] = 64'h0000_0000_FFFF_FFF9; b[3] = 64'd16; e[3] = 64'd9;
      t[4] = T_DIVUW; a[4] = 64'h0000_0000_FFFF_FFF0; b[4] = 64'd1;  e[4] = 64'hFFFF_FFFF_FFFF_FFF0;
      for (int i = 0; i < 5; i++) begin
         run_op(t[i], a[i], b[i], lat, res, st);
         checks++;
         if (lat !== 33) begin
            errors++;
            $display("FAIL opw[%0d] latency: got %0d expected 33", i, lat);
         end
         checks++;
         if (res !== e[i]) begin
            errors++;
            $display("FAIL opw[%0d] value: got %h expected %h", i, res, e[i]);
         end
         release_op();
      end
   endtask

   task automatic test_special();
      logic [7:0]  t [6];
      logic [63:0] a [6];
      logic [63:0] b [6];
      logic [63:0] e [6];
      int          lat;
      logic [63:0] res;
      logic        st;
      t[0] = T_DIVU;  a[0] = 64'h1234;                b[0] = 64'd0;                  e[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      t[1] = T_REMU;  a[1] = 64'h1234;                b[1] = 64'd0;                  e[1] = 64'h1234;
      t[2] = T_DIV;   a[2] = 64'h8000_0000_0000_0000; b[2] = 64'hFFFF_FFFF_FFFF_FFFF; e[2] = 64'h8000_0000_0000_0000;
      t[3] = T_REM;   a[3] = 64'h8000_0000_0000_0000; b[3] = 64'hFFFF_FFFF_FFFF_FFFF; e[3] = 64'd0;
      t[4] = T_DIVW;  a[4] = 64'h0000_0000_8000_0000; b[4] = 64'h0000_0000_FFFF_FFFF; e[4] = 64'hFFFF_FFFF_8000_0000;
      t[5] = T_REMUW; a[5] = 64'h0000_0000_8000_0001; b[5] = 64'd0;                  e[5] = 64'hFFFF_FFFF_8000_0001;
      for (int i = 0; i < 6; i++) begin
         run_op(t[i], a[i], b[i], lat, res, st);
         checks++;
         if (lat !== 1) begin
            errors++;
            $display("FAIL special[%0d] latency: got %0d expected 1", i, lat);
         end
         checks++;
         if (res !== e[i]) begin
            errors++;
            $display("FAIL special[%0d] value: got %h expected %h", i, res, e[i]);
         end
         release_op();
      end
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic [63:0] res;
      logic        st;
      result_ready = 1'b0;
      run_op(T_DIVU, 64'd1000, 64'd10, lat, res, st);
      checks++;
      if (lat !== 65 || res !== 64'd100) begin
         errors++;
         $display("FAIL bp_first: got lat=%0d out=%h expected 65 %h", lat, res, 64'd100);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (result_ok !== 1'b1 || div_out !== 64'd100 || div_stall !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got ok=%b out=%h stall=%b expected 1 %h 0",
                     c, result_ok, div_out, div_stall, 64'd100);
         end
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (result_ok !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: got ok=%b expected 0", result_ok);
      end
      run_op(T_DIVU, 64'd100, 64'd7, lat, res, st);
      checks++;
      if (lat !== 65 || res !== 64'd14) begin
         errors++;
         $display("FAIL bp_next: got lat=%0d out=%h expected 65 %h", lat, res, 64'd14);
      end
      release_op();
   endtask

   task automatic test_valid_drop();
      int n;
      result_ready = 1'b0;
      div_type   = T_DIV;
      dividend_i = 64'd1000;
      divisor_i  = 64'hFFFF_FFFF_FFFF_FFF9;
      div_valid  = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      div_valid = 1'b0;
      div_type  = 8'h00;
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (result_ok) begin
            n = k;
            break;
         end
      end
      checks++;
      if (n + 10 !== 65 || div_out !== 64'hFFFF_FFFF_FFFF_FF72) begin
         errors++;
         $display("FAIL valid_drop: got lat=%0d out=%h expected 65 %h",
                  n + 10, div_out, 64'hFFFF_FFFF_FFFF_FF72);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (result_ok !== 1'b1) begin
         errors++;
         $display("FAIL valid_drop_wait: got ok=%b expected 1", result_ok);
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (result_ok !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop_release: got ok=%b expected 0", result_ok);
      end
   endtask

   task automatic test_reset_mid_calc();
      int          lat;
      logic [63:0] res;
      logic        st;
      div_type   = T_DIVU;
      dividend_i = 64'd100;
      divisor_i  = 64'd7;
      div_valid  = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (result_ok !== 1'b0 || div_out !== 64'd0 || div_stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got ok=%b out=%h stall=%b expected 0 0 1",
                  result_ok, div_out, div_stall);
      end
      rst_n = 1'b0;
      run_op(T_DIVU, 64'd100, 64'd7, lat, res, st);
      checks++;
      if (lat !== 65 || res !== 64'd14) begin
         errors++;
         $display("FAIL reset_recover: got lat=%0d out=%h expected 65 %h", lat, res, 64'd14);
      end
      release_op();
   endtask

`ifdef DIV_FLUSH_EN
   task automatic test_flush();
      int          pulses;
      int          lat;
      logic [63:0] res;
      logic        st;
      div_type   = T_DIV;
      dividend_i = 64'd100;
      divisor_i  = 64'hFFFF_FFFF_FFFF_FFF9;
      div_valid  = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      checks++;
      if (div_stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_stall: got %b expected 0", div_stall);
      end
      @(posedge clk); #1;
      flush     = 1'b0;
      div_valid = 1'b0;
      div_type  = 8'h00;
      pulses = 0;
      for (int k = 0; k < 70; k++) begin
         @(posedge clk); #1;
         if (result_ok) pulses++;
      end
      checks++;
      if (pulses !== 0 || div_out !== 64'd14) begin
         errors++;
         $display("FAIL flush_abort: got pulses=%0d out=%h expected 0 %h", pulses, div_out, 64'd14);
      end
      run_op(T_DIV, 64'd7, 64'd2, lat, res, st);
      checks++;
      if (lat !== 65 || res !== 64'd3) begin
         errors++;
         $display("FAIL flush_next: got lat=%0d out=%h expected 65 %h", lat, res, 64'd3);
      end
      release_op();
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b1;
      flush        = 1'b0;
      div_valid    = 1'b0;
      div_type     = 8'h00;
      dividend_i   = 64'd0;
      divisor_i    = 64'd0;
      result_ready = 1'b1;
      test_reset();
      test_signed64();
      test_word();
      test_special();
      test_back_to_back();
      test_valid_drop();
      test_reset_mid_calc();
`ifdef DIV_FLUSH_EN
      test_flush();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050019_divider_cycle.md
Name: ysyx_22050019_divider_cycle

Overview:
- Multi-cycle radix-2 restoring integer divider; the responder for the ALU's offload handshake.
- Uses the same valid / stall / ok / ready protocol as the multiplier responder.
- Replaces the combinational `/` and `%` paths in the EX stage for RV64M DIV/DIVU/REM/REMU and the W variants.
- Holds the pipeline via `div_stall` until the result is presented and accepted.

Parameters:
- XLEN, 64, operand/result width; W ops use the low XLEN/2 bits.
- CNT_W, 7, iteration counter width (must hold XLEN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-high (port named rst_n for codebase consistency; asserted = 1).
- div_valid  in  1  request, held high by the ALU while a divide op is in EX.
- div_type  in  8  one-hot op select, same order as alu_sel[28:21]: [0] rem, [1] remu, [2] remuw, [3] remw, [4] div, [5] divu, [6] divuw, [7] divw.
- dividend_i  in  XLEN  op_1.
- divisor_i  in  XLEN  op_2.
- result_ready  in  1  downstream (~lsu_stall) can take the result.
- div_out  out  XLEN  quotient or remainder; W results are sign-extended from bit 31.
- div_stall  out  1  pipeline hold.
- result_ok  out  1  div_out is valid.
- flush  in  1  present only with DIV_FLUSH_EN.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst_n=1 at a clk edge): state=IDLE, counter=0, div_out=0, result_ok=0; all internal registers cleared. Reset takes priority over everything, including mid-CALC.

IDLE:
- On div_valid=1: latch |operands|, negation flags and the op kind (signed, rem-select, W). Go to CALC with counter=XLEN, or XLEN/2 for W ops.
- Signed ops take the magnitude of each operand. For W ops, the low 32 bits are first sign-extended (signed) or zero-extended (unsigned).
- Special cases resolve in the accept cycle and go straight to DONE (latency 1), with no iteration:
  - Divisor == 0: quotient = all ones; remainder = dividend (W: low 32 bits, sign-extended).
  - Signed overflow (dividend = most-negative, divisor = -1, at the op width): quotient = dividend; remainder = 0.

CALC:
- Each cycle: shift {rem, quot} left by 1, trial-subtract the divisor, set the quotient LSB, restore on borrow. Decrement the counter.
- When the counter reaches 1: apply sign correction. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign. Register div_out, go to DONE.

DONE:
- result_ok=1 and div_out held stable.
- If result_ready=1: go to IDLE that cycle. If result_ready=0: hold indefinitely.

div_stall and result_ok:
- div_stall = div_valid & (state != DONE). This is combinational, so the stall is asserted in the request cycle itself.
- result_ok = (state == DONE), registered.

Latency from div_valid to result_ok:
- 64-bit ops: 65 cycles.
- W ops: 33 cycles.
- Special cases: 1 cycle.

Boundary conditions:
- div_type not one-hot while div_valid=1: treated as div (signed 64-bit); assertion fires in simulation.
- div_valid dropping mid-CALC (without flush): the computation continues to DONE; the result waits for result_ready.
- Back-to-back requests: a new request can be accepted the cycle after a DONE→IDLE transition. No re-launch occurs on the same instruction because the ALU advances when result_ready=1.

Optional Feature:
- Macro DIV_FLUSH_EN.
- Defined:
  - `flush` port present.
  - flush=1 in any state forces IDLE the next cycle, with result_ok=0 and div_out unchanged.
  - flush has priority over div_valid in IDLE, so no accept occurs.
  - div_stall is forced 0 while flush=1.
- Undefined: no flush port; an operation always runs to DONE.

Decomposition:
- Shared package ysyx_22050019_div_pkg:
  - DIV_TYPE bit indices (REM, REMU, REMUW, REMW, DIV, DIVU, DIVUW, DIVW).
  - State encoding localparams IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - XLEN default.
- Sub-module ysyx_22050019_div_sign_fix (combinational pre-abs and post-negate/sign-extend), instantiated once for input and once for output.

Test Plan:
- div, dividend=-20 (0xFFFF_FFFF_FFFF_FFEC), divisor=3, result_ready=1 → after 65 cycles result_ok=1, div_out=0xFFFF_FFFF_FFFF_FFFA (-6); rem of the same operands → 0xFFFF_FFFF_FFFF_FFFE (-2).
- divuw, dividend=0x1_8000_0000, divisor=2 → 33 cycles, div_out=0x0000_0000_4000_0000; remw with 0xFFFF_FFF9 % 2 → 0xFFFF_FFFF_FFFF_FFFF (-1).
- divu with divisor=0, dividend=0x1234 → result_ok on the next cycle, div_out=0xFFFF_FFFF_FFFF_FFFF; remu of the same operands → 0x1234. div with dividend=0x8000_0000_0000_0000, divisor=-1 → div_out=0x8000_0000_0000_0000, latency 1.
- Backpressure: result_ready=0 for 10 cycles after DONE → result_ok, div_out and div_stall all stable; then result_ready=1 → IDLE next cycle. Immediately issue divu 100/7 → div_out=14.
- Reset asserted at CALC cycle 20 → next cycle state=IDLE, result_ok=0, div_out=0, div_stall=div_valid.
- DIV_FLUSH_EN build: flush at CALC cycle 5 → IDLE next cycle, no result_ok pulse; a following div 7/2 returns 3.
